// File: rtl/program_counter.sv
// WIDTH-bit program counter for the instruction-fetch path. The per-bit next value
// is a select chain (increment, then load, then clear) feeding registered outputs.
module program_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             inc,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             wrap
);

    // 2:1 select primitive: returns b when s is high, otherwise a.
    function automatic logic sel2(input logic s, input logic a, input logic b);
        return s ? b : a;
    endfunction

    // Half adder: returns {carry, sum}.
    function automatic logic [1:0] halfAdd(input logic a, input logic b);
        return {a & b, a ^ b};
    endfunction

    logic [WIDTH-1:0] outR;
    logic             wrapR;
    logic [WIDTH:0]   carryS;
    logic [WIDTH-1:0] sumS;
    logic [WIDTH-1:0] incPathS;
    logic [WIDTH-1:0] loadPathS;
    logic [WIDTH-1:0] nextOutS;
    logic             wrapNextS;

    // A carry-in tied high turns the half-adder ripple chain into an incrementer.
    assign carryS[0] = 1'b1;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            assign {carryS[i+1], sumS[i]} = halfAdd(outR[i], carryS[i]);
            assign incPathS[i]  = sel2(inc,   outR[i],      sumS[i]);
            assign loadPathS[i] = sel2(load,  incPathS[i],  in[i]);
            assign nextOutS[i]  = sel2(reset, loadPathS[i], 1'b0);
        end
    endgenerate

    // The MSB carry only counts as a wrap when the increment branch is the one taken.
    assign wrapNextS = sel2(reset, sel2(load, inc & carryS[WIDTH], 1'b0), 1'b0);

    // Counter and wrap flag registers; clearing is already folded into the next-value chain.
    always_ff @(posedge clk) begin
        outR  <= nextOutS;
        wrapR <= wrapNextS;
    end

    assign out  = outR;
    assign wrap = wrapR;

endmodule
